spike_rate_encoder: RTL and testbench
=====================================

Name: spike_rate_encoder

Overview:
- Converts an 8-bit intensity sample into a rate-coded spike train over a fixed window of WINDOW clock cycles.
- The window is built on an 8-bit phase accumulator. A spike is emitted on every accumulator carry.
- It sits upstream of the LIF neuron core and drives the 1-bit spike input that the core integrates into V_mem. It is the encode side of the neuron's spike interface.
- A valid/ready handshake accepts one sample per window. A per-window spike count and a done pulse are reported.

Parameters:
- WINDOW, 256, number of clock cycles per encoding window. Legal range is 1..256.
- CNT_W, $clog2(WINDOW+1), width of spike_count. Derived; do not override.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- in_data  input  8  intensity sample, unsigned
- in_valid  input  1  in_data valid
- in_ready  output  1  encoder idle, can accept a sample
- spike  output  1  registered spike, one cycle wide per event
- busy  output  1  window in progress
- win_done  output  1  single-cycle pulse at the end of each window
- spike_count  output  CNT_W  spikes emitted in the current/last window

Behaviour:
- Reset (synchronous, active-high, highest priority):
  - state=IDLE, acc=0, sample reg=0, cycle counter=0.
  - spike=0, busy=0, win_done=0, spike_count=0.
  - in_ready=0 while reset is high.
- States:
  - IDLE: in_ready=1 (combinational from state, gated by !reset), busy=0.
    - in_valid&&in_ready at edge E0: latch in_data, acc<=ACC_INIT, cnt<=0, spike_count<=0, go to RUN.
  - RUN: in_ready=0, busy=1. in_valid is ignored and no sample is latched.
    - At each edge Ek, k=1..WINDOW: {carry,acc}<=acc+sample (9-bit add), spike<=carry, spike_count<=spike_count+carry, cnt<=cnt+1.
    - At EWINDOW: win_done<=1 for one cycle, state<=IDLE.
- spike is 0 in every cycle it is not set by a RUN update. In particular it is 0 the cycle after EWINDOW.
- Latency: first possible spike is visible after E1. The last window spike and win_done are visible together after EWINDOW.
- Total spikes per window = floor((sample*WINDOW + ACC_INIT)/256). With default ACC_INIT=0 and WINDOW=256 this equals the sample exactly.
- Spikes are evenly distributed; successive gaps differ by at most one cycle.
- spike_count:
  - Holds its final value from EWINDOW until the next accept, which clears it.
  - Never exceeds WINDOW (sample<=255, so at most one carry per cycle).
- Boundaries:
  - sample=0: no spikes, win_done still pulses.
  - sample=255, WINDOW=256: 255 spikes.
  - WINDOW=1: RUN lasts one edge.
- Back-to-back: earliest next accept is at E(WINDOW+1), giving a one-cycle IDLE gap.
- Reset asserted mid-RUN aborts the window immediately. No win_done is produced and all outputs go to their reset values on that edge.

Optional Feature:
- Macro: SPIKE_ENC_ROUND_EN
- Defined: ACC_INIT=8'h80. The count rounds to nearest: floor((sample*WINDOW+128)/256), and the spike phase shifts half a period earlier.
- Undefined: ACC_INIT=8'h00, truncating count as above.
- No port or latency change in either case.

Decomposition:
- Package spike_enc_pkg holds:
  - state enum {IDLE, RUN};
  - ACC_W=8;
  - ACC_INIT_TRUNC=8'h00 and ACC_INIT_ROUND=8'h80.
- One sub-module, spike_phase_acc:
  - 8-bit accumulator with load (init value), enable, and add-with-carry;
  - outputs carry as the spike.
- The top level owns the FSM, cycle counter, spike_count and handshake.

Test Plan:
- Reset mid-RUN after 10 cycles: the next edge forces busy=0, spike=0, spike_count=0, in_ready=1 after reset drops, and no win_done.
- WINDOW=256, in_data=0x80, round off:
  - spikes after E2,E4,…,E256 (alternate cycles);
  - spike_count=128, win_done after E256.
- WINDOW=16, in_data=0x10:
  - round off: a single spike together with win_done after E16, spike_count=1.
  - round on: a single spike after E8, spike_count=1.
- in_data=0x00 and in_data=0xFF with WINDOW=256:
  - 0x00: spike never high, count=0;
  - 0xFF: count=255, exactly one missing spike;
  - win_done in both.
- in_valid held high continuously:
  - sample changes during RUN are ignored;
  - next accept occurs at E257 with one in_ready cycle between windows;
  - spike_count clears on accept.
- Random samples over 50 windows: spike_count equals the formula for the compiled mode, and no spike appears outside busy.

Source files
------------

// File: rtl/spike_enc_pkg.sv
// Shared types and constants for the spike rate encoder.
// Both accumulator start phases live here; the top picks one via SPIKE_ENC_ROUND_EN.
package spike_enc_pkg;

    typedef enum logic {
        IDLE,
        RUN
    } enc_state_e;

    localparam int ACC_W = 8;

    localparam logic [ACC_W-1:0] ACC_INIT_TRUNC = 8'h00;
    localparam logic [ACC_W-1:0] ACC_INIT_ROUND = 8'h80;

endpackage

// File: rtl/spike_phase_acc.sv
// Phase accumulator for the encoder: loads a start phase, then adds the sample each
// enabled cycle. The carry out of the 8-bit add is the raw spike.
module spike_phase_acc
    import spike_enc_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [ACC_W-1:0] init_i,
    input  logic [ACC_W-1:0] addend_i,
    output logic             carry_o
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W:0]   sum;

    always_comb begin
        sum   = {1'b0, acc_q} + {1'b0, addend_i};
        acc_d = acc_q;
        if (load_i) begin
            acc_d = init_i;
        end else if (en_i) begin
            acc_d = sum[ACC_W-1:0];
        end
        carry_o = en_i & sum[ACC_W];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/spike_rate_encoder.sv
// Rate-codes an 8-bit intensity into a spike train over WINDOW cycles per accepted sample.
// Define SPIKE_ENC_ROUND_EN to start the phase at half scale (round-to-nearest spike count).
module spike_rate_encoder
    import spike_enc_pkg::*;
#(
    parameter int WINDOW = 256,
    parameter int CNT_W  = $clog2(WINDOW + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             spike,
    output logic             busy,
    output logic             win_done,
    output logic [CNT_W-1:0] spike_count
);

`ifdef SPIKE_ENC_ROUND_EN
    localparam logic [ACC_W-1:0] ACC_INIT = ACC_INIT_ROUND;
`else
    localparam logic [ACC_W-1:0] ACC_INIT = ACC_INIT_TRUNC;
`endif

    enc_state_e       state_q, state_d;
    logic [ACC_W-1:0] sample_q, sample_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             spike_q, spike_d;
    logic             done_q, done_d;
    logic             acc_load;
    logic             acc_en;
    logic             carry;
    logic             accept;
    logic             last;

    assign in_ready = (state_q == IDLE) & ~reset;
    assign busy     = (state_q == RUN);
    assign accept   = in_valid & in_ready;
    assign last     = (cnt_q == CNT_W'(WINDOW - 1));

    spike_phase_acc u_acc (
        .clk      (clk),
        .reset    (reset),
        .load_i   (acc_load),
        .en_i     (acc_en),
        .init_i   (ACC_INIT),
        .addend_i (sample_q),
        .carry_o  (carry)
    );

    always_comb begin
        state_d  = state_q;
        sample_d = sample_q;
        cnt_d    = cnt_q;
        count_d  = count_q;
        spike_d  = 1'b0;
        done_d   = 1'b0;
        acc_load = 1'b0;
        acc_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    sample_d = in_data;
                    cnt_d    = '0;
                    count_d  = '0;
                    acc_load = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                // cnt_q holds k-1 at edge Ek, so the window closes when it reaches WINDOW-1
                acc_en  = 1'b1;
                spike_d = carry;
                count_d = count_q + CNT_W'(carry);
                cnt_d   = cnt_q + CNT_W'(1);
                if (last) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            sample_q <= '0;
            cnt_q    <= '0;
            count_q  <= '0;
            spike_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sample_q <= sample_d;
            cnt_q    <= cnt_d;
            count_q  <= count_d;
            spike_q  <= spike_d;
            done_q   <= done_d;
        end
    end

    assign spike       = spike_q;
    assign win_done    = done_q;
    assign spike_count = count_q;

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Bench for spike_rate_encoder at WINDOW = 256, 16 and 1; expected spikes come from
// floor((sample*k + init)/256) evaluated per cycle.
module tb_spike_rate_encoder;

`ifdef SPIKE_ENC_ROUND_EN
    localparam int unsigned INIT = 128;
`else
    localparam int unsigned INIT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst  [3];
    logic [7:0] din  [3];
    logic       vld  [3];
    logic       rdy  [3];
    logic       spk  [3];
    logic       bsy  [3];
    logic       dn   [3];
    logic [8:0] cnt_a;
    logic [4:0] cnt_b;
    logic [0:0] cnt_c;

    int unsigned win_of [3] = '{256, 16, 1};
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    spike_rate_encoder #(.WINDOW(256)) u_a (
        .clk(clk), .reset(rst[0]), .in_data(din[0]), .in_valid(vld[0]), .in_ready(rdy[0]),
        .spike(spk[0]), .busy(bsy[0]), .win_done(dn[0]), .spike_count(cnt_a)
    );
    spike_rate_encoder #(.WINDOW(16)) u_b (
        .clk(clk), .reset(rst[1]), .in_data(din[1]), .in_valid(vld[1]), .in_ready(rdy[1]),
        .spike(spk[1]), .busy(bsy[1]), .win_done(dn[1]), .spike_count(cnt_b)
    );
    spike_rate_encoder #(.WINDOW(1)) u_c (
        .clk(clk), .reset(rst[2]), .in_data(din[2]), .in_valid(vld[2]), .in_ready(rdy[2]),
        .spike(spk[2]), .busy(bsy[2]), .win_done(dn[2]), .spike_count(cnt_c)
    );

    function automatic logic [31:0] cnt_of(input int d);
        case (d)
            0:       return 32'(cnt_a);
            1:       return 32'(cnt_b);
            default: return 32'(cnt_c);
        endcase
    endfunction

    // Spikes emitted after k RUN edges for sample s.
    function automatic int unsigned model(input int unsigned s, input int unsigned k);
        return (s * k + INIT) / 256;
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_window(input int d, input int unsigned s, input bit hold);
        int unsigned w;
        int unsigned prev;
        int unsigned cur;
        int          budget;
        w      = win_of[d];
        budget = 0;
        while (rdy[d] !== 1'b1 && budget < 20) begin
            tick();
            budget++;
        end
        check("ready_before_accept", 32'(rdy[d]), 1);
        din[d] = s[7:0];
        vld[d] = 1'b1;
        tick();
        check("accept_ready", 32'(rdy[d]), 0);
        check("accept_busy", 32'(bsy[d]), 1);
        check("accept_count_clear", cnt_of(d), 0);
        check("accept_spike", 32'(spk[d]), 0);
        check("accept_done", 32'(dn[d]), 0);
        if (!hold) vld[d] = 1'b0;
        prev = model(s, 0);
        for (int unsigned k = 1; k <= w; k++) begin
            if (hold) din[d] = 8'($urandom);
            tick();
            cur = model(s, k);
            check("spike", 32'(spk[d]), cur - prev);
            check("count", cnt_of(d), cur);
            check("done", 32'(dn[d]), 32'(k == w));
            check("busy", 32'(bsy[d]), 32'(k < w));
            check("ready", 32'(rdy[d]), 32'(k == w));
            prev = cur;
        end
    endtask

    task automatic idle_check(input int d, input int unsigned exp_cnt);
        tick();
        check("idle_spike", 32'(spk[d]), 0);
        check("idle_done", 32'(dn[d]), 0);
        check("idle_ready", 32'(rdy[d]), 1);
        check("idle_busy", 32'(bsy[d]), 0);
        check("idle_count_hold", cnt_of(d), exp_cnt);
    endtask

    task automatic window(input int d, input int unsigned s);
        run_window(d, s, 1'b0);
        idle_check(d, model(s, win_of[d]));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1;
            vld[i] = 1'b1;
            din[i] = 8'hFF;
        end
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            check("reset_ready", 32'(rdy[i]), 0);
            check("reset_busy", 32'(bsy[i]), 0);
            check("reset_spike", 32'(spk[i]), 0);
            check("reset_done", 32'(dn[i]), 0);
            check("reset_count", cnt_of(i), 0);
            vld[i] = 1'b0;
            rst[i] = 1'b0;
        end
        #1;
        for (int i = 0; i < 3; i++) check("ready_after_reset", 32'(rdy[i]), 1);

        // Directed boundary samples on every window length.
        window(0, 8'h80);
        window(0, 8'h00);
        window(0, 8'hFF);
        window(0, 8'h01);
        window(1, 8'h10);
        window(1, 8'h00);
        window(1, 8'hFF);
        window(2, 8'hFF);
        window(2, 8'h80);
        window(2, 8'h7F);
        window(2, 8'h00);

        // in_valid held high: back-to-back windows with a one-cycle ready gap.
        for (int n = 0; n < 3; n++) run_window(0, $urandom_range(255), 1'b1);
        vld[0] = 1'b0;
        tick();
        run_window(1, 8'h10, 1'b1);
        run_window(1, 8'hC3, 1'b1);
        vld[1] = 1'b0;
        tick();

        // Reset in the middle of a window.
        din[0] = 8'hFF;
        vld[0] = 1'b1;
        tick();
        vld[0] = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("midrun_busy_before", 32'(bsy[0]), 1);
        rst[0] = 1'b1;
        tick();
        check("midrun_busy", 32'(bsy[0]), 0);
        check("midrun_spike", 32'(spk[0]), 0);
        check("midrun_count", cnt_of(0), 0);
        check("midrun_done", 32'(dn[0]), 0);
        check("midrun_ready_in_reset", 32'(rdy[0]), 0);
        rst[0] = 1'b0;
        #1;
        check("midrun_ready_after", 32'(rdy[0]), 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("midrun_no_done", 32'(dn[0]), 0);
            check("midrun_no_spike", 32'(spk[0]), 0);
        end

        // Random samples over 50 windows spread across the three window lengths.
        for (int n = 0; n < 50; n++) begin
            int d;
            d = (n % 5 == 0) ? 0 : ((n % 5 < 3) ? 1 : 2);
            window(d, $urandom_range(255));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
